// File: rtl/gpa_pkg.sv
// Shared constants, FSM states and the round-robin search helper for group_port_arbiter.
package gpa_pkg;

  localparam int DATA_W   = 16;
  localparam int HEADER_W = 6;
  localparam int GRP_W    = 4;
  localparam int LEAF_W   = 2;
  localparam int GRP_MSB  = DATA_W - 1;
  localparam int GRP_LSB  = DATA_W - GRP_W;
  localparam int LEAF_MSB = DATA_W - GRP_W - 1;
  localparam int LEAF_LSB = DATA_W - HEADER_W;
  localparam int MAX_REQ  = 4;
  localparam int IDX_W    = 2;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid_vec at or after start_idx, wrapping within num entries.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                       input logic [IDX_W-1:0]   start_idx,
                                       input int                 num);
    rr_pick_t         r;
    logic [IDX_W-1:0] pos;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(start_idx) + k) % num);
      if (k < num && valid_vec[pos]) begin
        r.found = 1'b1;
        r.idx   = pos;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gpa_rr_arbiter.sv
// Round-robin uplink arbiter with bounded bursts; owns the FSM, burst count and last grant.
module gpa_rr_arbiter
  import gpa_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               load_ok,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   last_grant, last_next, start_idx;
  logic [3:0]         burst_cnt, burst_next;
  logic [MAX_REQ-1:0] valid_all;
  rr_pick_t           pick;

  assign valid_all = MAX_REQ'(req_valid);
  assign start_idx = IDX_W'((int'(last_grant) + 1) % NUM_REQ);
  // Searching from owner+1 visits the owner last, so it is re-picked only when it is alone.
  assign pick      = rr_pick(valid_all, start_idx, NUM_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_next;
      burst_cnt  <= burst_next;
    end
  end

  always_comb begin
    state_next  = state;
    last_next   = last_grant;
    burst_next  = burst_cnt;
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    case (state)
      IDLE: begin
        if (load_ok && pick.found) begin
          grant_valid = 1'b1;
          grant_idx   = pick.idx;
          last_next   = pick.idx;
          burst_next  = 4'd1;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (load_ok) begin
          if (valid_all[last_grant] && burst_cnt < 4'(MAX_BURST)) begin
            grant_valid = 1'b1;
            burst_next  = burst_cnt + 4'd1;
          end else if (pick.found) begin
            grant_valid = 1'b1;
            grant_idx   = pick.idx;
            last_next   = pick.idx;
            burst_next  = 4'd1;
          end else begin
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/group_port_arbiter.sv
// GPU group port: arbitrated uplink to the group router and leaf-addressed downlink demux.
// Optional per-requester grant and drop statistics are enabled by defining GPA_GRANT_STATS_EN.
module group_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = gpa_pkg::DATA_W,
  parameter int GROUP_ID  = 7,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         up_data,
  output logic                      up_valid,
  input  logic                      up_ready,
  input  logic [DATA_W-1:0]         dn_data,
  input  logic                      dn_valid,
  output logic                      dn_ready,
  output logic [DATA_W-1:0]         leaf_data,
  output logic [NUM_REQ-1:0]        leaf_valid,
  input  logic [NUM_REQ-1:0]        leaf_ready,
  output logic                      drop_pulse
`ifdef GPA_GRANT_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
  output logic [7:0]                drop_cnt
`endif
);
  import gpa_pkg::*;

  logic                load_ok;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic [GRP_W-1:0]    dn_grp;
  logic [LEAF_W-1:0]   dn_leaf;
  logic                dn_match;
  logic [NUM_REQ-1:0]  dn_onehot;
  logic                leaf_taken;

  assign load_ok = !up_valid || up_ready;

  gpa_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .load_ok     (load_ok),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_data     = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = grant_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_valid <= 1'b0;
      up_data  <= '0;
    end else if (grant_valid) begin
      up_valid <= 1'b1;
      up_data  <= sel_data;
    end else if (up_ready) begin
      up_valid <= 1'b0;
    end
  end

  assign dn_grp     = dn_data[DATA_W-1 -: GRP_W];
  assign dn_leaf    = dn_data[DATA_W-1-GRP_W -: LEAF_W];
  assign leaf_taken = |(leaf_valid & leaf_ready);
  assign dn_ready   = !(|leaf_valid) || leaf_taken;

  // Leaf codes with no attached NI never match, so they are dropped like foreign groups.
  always_comb begin
    dn_onehot = '0;
    dn_match  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (dn_leaf == LEAF_W'(i)) begin
        dn_onehot[i] = 1'b1;
        dn_match     = (dn_grp == GRP_W'(GROUP_ID));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leaf_valid <= '0;
      leaf_data  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (dn_valid && dn_ready) begin
        if (dn_match) begin
          leaf_valid <= dn_onehot;
          leaf_data  <= dn_data;
        end else begin
          leaf_valid <= '0;
          drop_pulse <= 1'b1;
        end
      end else if (leaf_taken) begin
        leaf_valid <= '0;
      end
    end
  end

`ifdef GPA_GRANT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_valid && grant_idx == IDX_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (drop_pulse && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_group_port_arbiter.sv
// Bench for group_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_group_port_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int GID = 7;
  localparam int MB  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     up_data;
  logic             up_valid;
  logic             up_ready;
  logic [W-1:0]     dn_data;
  logic             dn_valid;
  logic             dn_ready;
  logic [W-1:0]     leaf_data;
  logic [N-1:0]     leaf_valid;
  logic [N-1:0]     leaf_ready;
  logic             drop_pulse;
`ifdef GPA_GRANT_STATS_EN
  logic             stats_clr;
  logic [N*16-1:0]  grant_cnt;
  logic [7:0]       drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: burst owner and its run length, plus the two output registers.
  int          m_owner;
  int          m_run;
  logic        m_up_valid;
  logic [15:0] m_up_data;
  logic [3:0]  m_lv;
  logic [15:0] m_ld;
  logic        m_drop;

  group_port_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .GROUP_ID  (GID),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .dn_data    (dn_data),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .leaf_data  (leaf_data),
    .leaf_valid (leaf_valid),
    .leaf_ready (leaf_ready),
    .drop_pulse (drop_pulse)
`ifdef GPA_GRANT_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    req_valid  = '0;
    req_data   = '0;
    up_ready   = 1'b0;
    dn_valid   = 1'b0;
    dn_data    = '0;
    leaf_ready = '0;
`ifdef GPA_GRANT_STATS_EN
    stats_clr  = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_owner    = N - 1;
    m_run      = MB;
    m_up_valid = 1'b0;
    m_up_data  = '0;
    m_lv       = '0;
    m_ld       = '0;
    m_drop     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (up_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_up_valid: got %b expected 0", up_valid); end
    checks++; if (up_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_up_data: got %h expected 0000", up_data); end
    checks++; if (leaf_valid !== 4'b0) begin errors++; $display("[TB] FAIL reset_leaf_valid: got %b expected 0000", leaf_valid); end
    checks++; if (leaf_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_leaf_data: got %h expected 0000", leaf_data); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop_pulse: got %b expected 0", drop_pulse); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (dn_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dn_ready: got %b expected 1", dn_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid      = 4'b0001;
    req_data[15:0] = 16'h7A05;
    up_ready       = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_req_ready: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (up_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_up_valid: got %b expected 1", up_valid); end
    checks++; if (up_data !== 16'h7A05) begin errors++; $display("[TB] FAIL single_up_data: got %h expected 7a05", up_data); end
  endtask

  task automatic test_burst_rotation();
    int seen [N];
    int exp_g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = 16'hA000 + 16'(i);
      seen[i] = 0;
    end
    req_valid = 4'b1111;
    up_ready  = 1'b1;
    for (int n = 0; n < 32; n++) begin
      exp_g = (n / MB) % N;
      #1;
      checks++; if (req_ready !== 4'(1 << exp_g)) begin errors++; $display("[TB] FAIL rotation_grant[%0d]: got %b expected %b", n, req_ready, 4'(1 << exp_g)); end
      for (int g = 0; g < N; g++) if (req_ready[g] === 1'b1) seen[g]++;
      @(posedge clk); #1;
      checks++; if (up_valid !== 1'b1 || up_data !== 16'hA000 + 16'(exp_g)) begin errors++; $display("[TB] FAIL rotation_up[%0d]: got valid=%b data=%h expected valid=1 data=%h", n, up_valid, up_data, 16'hA000 + 16'(exp_g)); end
    end
    for (int g = 0; g < N; g++) begin
      checks++; if (seen[g] != 8) begin errors++; $display("[TB] FAIL rotation_share[%0d]: got %0d expected 8", g, seen[g]); end
    end
`ifdef GPA_GRANT_STATS_EN
    for (int g = 0; g < N; g++) begin
      checks++; if (grant_cnt[g*16 +: 16] !== 16'd8) begin errors++; $display("[TB] FAIL stats_grant_cnt[%0d]: got %0d expected 8", g, grant_cnt[g*16 +: 16]); end
    end
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    checks++; if (grant_cnt !== '0) begin errors++; $display("[TB] FAIL stats_clear: got %h expected 0", grant_cnt); end
`endif
    req_valid = 4'b0000;
  endtask

  task automatic test_stall();
    int exp_g;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA000 + 16'(i);
    req_valid = 4'b1111;
    up_ready  = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_g = (n / MB) % N;
      #1;
      checks++; if (req_ready !== 4'(1 << exp_g)) begin errors++; $display("[TB] FAIL stall_pre_grant[%0d]: got %b expected %b", n, req_ready, 4'(1 << exp_g)); end
      @(posedge clk); #1;
    end
    up_ready = 1'b0;
    repeat (5) begin
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL stall_req_ready: got %b expected 0000", req_ready); end
      checks++; if (up_valid !== 1'b1 || up_data !== 16'hA001) begin errors++; $display("[TB] FAIL stall_hold: got valid=%b data=%h expected valid=1 data=a001", up_valid, up_data); end
      @(posedge clk); #1;
    end
    up_ready = 1'b1;
    for (int n = 6; n < 14; n++) begin
      exp_g = (n / MB) % N;
      #1;
      checks++; if (req_ready !== 4'(1 << exp_g)) begin errors++; $display("[TB] FAIL stall_resume[%0d]: got %b expected %b", n, req_ready, 4'(1 << exp_g)); end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_downlink();
    do_reset();
    leaf_ready = 4'b0000;
    dn_data    = 16'h7BFF;
    dn_valid   = 1'b1;
    #1;
    checks++; if (dn_ready !== 1'b1) begin errors++; $display("[TB] FAIL dn_empty_ready: got %b expected 1", dn_ready); end
    @(posedge clk); #1;
    dn_data = 16'h7000;
    #1;
    checks++; if (leaf_valid !== 4'b0100 || leaf_data !== 16'h7BFF) begin errors++; $display("[TB] FAIL dn_deliver: got valid=%b data=%h expected valid=0100 data=7bff", leaf_valid, leaf_data); end
    checks++; if (dn_ready !== 1'b0) begin errors++; $display("[TB] FAIL dn_backpressure: got %b expected 0", dn_ready); end
    repeat (3) @(posedge clk);
    #1;
    leaf_ready = 4'b1011;
    #1;
    checks++; if (leaf_valid !== 4'b0100 || leaf_data !== 16'h7BFF || dn_ready !== 1'b0) begin errors++; $display("[TB] FAIL dn_hold: got valid=%b data=%h ready=%b expected valid=0100 data=7bff ready=0", leaf_valid, leaf_data, dn_ready); end
    leaf_ready = 4'b0100;
    #1;
    checks++; if (dn_ready !== 1'b1) begin errors++; $display("[TB] FAIL dn_taken_ready: got %b expected 1", dn_ready); end
    @(posedge clk); #1;
    dn_valid   = 1'b0;
    leaf_ready = 4'b0001;
    checks++; if (leaf_valid !== 4'b0001 || leaf_data !== 16'h7000) begin errors++; $display("[TB] FAIL dn_second: got valid=%b data=%h expected valid=0001 data=7000", leaf_valid, leaf_data); end
    @(posedge clk); #1;
    checks++; if (leaf_valid !== 4'b0000) begin errors++; $display("[TB] FAIL dn_drain: got %b expected 0000", leaf_valid); end
  endtask

  task automatic test_drop();
    do_reset();
    leaf_ready = 4'b1111;
    dn_data    = 16'h83FF;
    dn_valid   = 1'b1;
    #1;
    checks++; if (dn_ready !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready: got %b expected 1", dn_ready); end
    @(posedge clk); #1;
    dn_valid = 1'b0;
    checks++; if (drop_pulse !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse_high: got %b expected 1", drop_pulse); end
    checks++; if (leaf_valid !== 4'b0000) begin errors++; $display("[TB] FAIL drop_no_leaf: got %b expected 0000", leaf_valid); end
    @(posedge clk); #1;
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("[TB] FAIL drop_pulse_low: got %b expected 0", drop_pulse); end
`ifdef GPA_GRANT_STATS_EN
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL stats_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA000 + 16'(i);
    req_valid  = 4'b0100;
    up_ready   = 1'b1;
    leaf_ready = 4'b0000;
    dn_data    = 16'h7BFF;
    dn_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    up_ready  = 1'b0;
    dn_valid  = 1'b0;
    #1;
    checks++; if (up_valid !== 1'b1 || leaf_valid !== 4'b0100) begin errors++; $display("[TB] FAIL midreset_setup: got up_valid=%b leaf_valid=%b expected 1 and 0100", up_valid, leaf_valid); end
    reset = 1'b1;
    #1;
    checks++; if (up_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_up_valid: got %b expected 0", up_valid); end
    checks++; if (leaf_valid !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_leaf_valid: got %b expected 0000", leaf_valid); end
    @(posedge clk); #1;
    reset    = 1'b0;
    up_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (up_data !== 16'hA000) begin errors++; $display("[TB] FAIL midreset_up_data: got %h expected a000", up_data); end
  endtask

  task automatic test_random(input int cycles);
    logic [3:0] acc_prev;
    logic       dn_acc_prev;
    logic [3:0] exp_rr;
    logic       exp_dn_rdy;
    logic       load_ok;
    logic       taken;
    bit         cont;
    int         g, hl, grp, leaf;
    do_reset();
    acc_prev    = '0;
    dn_acc_prev = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_prev[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*W +: W] = 16'($urandom);
        end
      end
      if (dn_acc_prev) dn_valid = 1'b0;
      if (!dn_valid && $urandom_range(0, 1) == 1) begin
        dn_valid = 1'b1;
        dn_data  = 16'($urandom);
        if ($urandom_range(0, 1) == 1) dn_data[15:12] = 4'd7;
      end
      up_ready   = ($urandom_range(0, 3) != 0);
      leaf_ready = 4'($urandom);
      #1;

      // A burst continues on the owner until it stops asking or hits the limit; otherwise the
      // next asking requester after the owner, in circular order, wins.
      load_ok = !m_up_valid || up_ready;
      g    = -1;
      cont = 1'b0;
      if (load_ok) begin
        if (req_valid[m_owner] && m_run < MB) begin
          g    = m_owner;
          cont = 1'b1;
        end else begin
          for (int k = 1; k <= N; k++)
            if (g < 0 && req_valid[(m_owner + k) % N]) g = (m_owner + k) % N;
        end
      end
      exp_rr = (g >= 0) ? 4'(1 << g) : 4'b0000;
      hl = -1;
      for (int i = 0; i < N; i++) if (m_lv[i]) hl = i;
      taken      = (hl >= 0) && leaf_ready[hl];
      exp_dn_rdy = (hl < 0) || taken;

      checks++; if (req_ready !== exp_rr) begin errors++; $display("[TB] FAIL rnd_req_ready[%0d]: got %b expected %b", c, req_ready, exp_rr); end
      checks++; if (dn_ready !== exp_dn_rdy) begin errors++; $display("[TB] FAIL rnd_dn_ready[%0d]: got %b expected %b", c, dn_ready, exp_dn_rdy); end
      checks++; if (up_valid !== m_up_valid) begin errors++; $display("[TB] FAIL rnd_up_valid[%0d]: got %b expected %b", c, up_valid, m_up_valid); end
      checks++; if (up_data !== m_up_data) begin errors++; $display("[TB] FAIL rnd_up_data[%0d]: got %h expected %h", c, up_data, m_up_data); end
      checks++; if (leaf_valid !== m_lv) begin errors++; $display("[TB] FAIL rnd_leaf_valid[%0d]: got %b expected %b", c, leaf_valid, m_lv); end
      checks++; if (leaf_data !== m_ld) begin errors++; $display("[TB] FAIL rnd_leaf_data[%0d]: got %h expected %h", c, leaf_data, m_ld); end
      checks++; if (drop_pulse !== m_drop) begin errors++; $display("[TB] FAIL rnd_drop_pulse[%0d]: got %b expected %b", c, drop_pulse, m_drop); end

      if (g >= 0) begin
        m_run      = cont ? m_run + 1 : 1;
        m_owner    = g;
        m_up_data  = req_data[g*W +: W];
        m_up_valid = 1'b1;
      end else begin
        if (load_ok) m_run = MB;
        if (up_ready) m_up_valid = 1'b0;
      end
      m_drop = 1'b0;
      if (dn_valid && exp_dn_rdy) begin
        grp  = int'(dn_data) / 4096;
        leaf = (int'(dn_data) / 1024) % 4;
        if (grp == GID && leaf < N) begin
          m_lv = 4'(1 << leaf);
          m_ld = dn_data;
        end else begin
          m_lv   = 4'b0000;
          m_drop = 1'b1;
        end
      end else if (taken) begin
        m_lv = 4'b0000;
      end
      acc_prev    = exp_rr;
      dn_acc_prev = dn_valid && exp_dn_rdy;
      @(posedge clk); #1;
    end
    req_valid = '0;
    dn_valid  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_rotation();
    test_stall();
    test_downlink();
    test_drop();
    test_reset_mid();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
